// File: rtl/seven_seg_capture.sv
// seven_seg_capture: recovers hex digits from a scanned, active-low
// 4-digit seven-segment bus (seg/an) and reports frames and errors.
// Ports: clk, reset (sync, high); seg[6:0] (a..g), dp (ignored), an[3:0];
// num0..num3 digit values, digit_valid, frame_done and pattern_err pulses,
// err_count (saturating).
module seven_seg_capture #(
  parameter int STABLE_CNT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic       dp,
  input  logic [3:0] an,
  output logic [3:0] num0,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       pattern_err,
  output logic [7:0] err_count
);

  logic [6:0]  r_seg_r;
  logic [3:0]  r_an_r;
  logic [10:0] r_prev;
  logic [7:0]  r_cnt;
  logic [3:0]  r_num [4];
  logic [3:0]  r_valid;
  logic [3:0]  r_seen;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_ec;

  logic [7:0]  w_cnt;
  logic        w_accept;
  logic        w_legal;
  logic [3:0]  w_val;
  logic        w_blank;
  logic        w_one;
  logic [1:0]  w_idx;
  logic [3:0]  w_sel;
  logic        w_cap;
  logic        w_err;
  logic [3:0]  w_seen_nxt;
  logic        w_done;
  logic        w_unused;

  assign w_unused = dp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg_r <= 7'h7F;
      r_an_r  <= 4'hF;
      r_prev  <= 11'h7FF;
      r_cnt   <= '0;
    end else begin
      r_seg_r <= seg;
      r_an_r  <= an;
      r_prev  <= {r_seg_r, r_an_r};
      r_cnt   <= w_cnt;
    end
  end

  // Count of the current cycle: the acceptance test uses this
  // combinational value so a capture lands STABLE_CNT+1 edges after
  // the input first appears.
  always_comb begin
    if ({r_seg_r, r_an_r} != r_prev) w_cnt = 8'd1;
    else if (r_cnt == 8'hFF)         w_cnt = r_cnt;
    else                             w_cnt = r_cnt + 8'd1;
  end

  assign w_accept = (w_cnt == 8'(STABLE_CNT));

  always_comb begin
    w_legal = 1'b1;
    w_val   = 4'h0;
    unique case (~r_seg_r)
      7'h3F: w_val = 4'h0;
      7'h06: w_val = 4'h1;
      7'h5B: w_val = 4'h2;
      7'h4F: w_val = 4'h3;
      7'h66: w_val = 4'h4;
      7'h6D: w_val = 4'h5;
      7'h7D: w_val = 4'h6;
      7'h07: w_val = 4'h7;
      7'h7F: w_val = 4'h8;
      7'h6F: w_val = 4'h9;
      7'h77: w_val = 4'hA;
      7'h7C: w_val = 4'hB;
      7'h39: w_val = 4'hC;
      7'h5E: w_val = 4'hD;
      7'h79: w_val = 4'hE;
      7'h71: w_val = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_blank = 1'b0;
    w_one   = 1'b0;
    w_idx   = 2'd0;
    unique case (1'b1)
      (r_an_r == 4'b1111): w_blank = 1'b1;
      (r_an_r == 4'b1110): begin w_one = 1'b1; w_idx = 2'd0; end
      (r_an_r == 4'b1101): begin w_one = 1'b1; w_idx = 2'd1; end
      (r_an_r == 4'b1011): begin w_one = 1'b1; w_idx = 2'd2; end
      (r_an_r == 4'b0111): begin w_one = 1'b1; w_idx = 2'd3; end
      default:             w_one = 1'b0;
    endcase
  end

  assign w_sel = w_one ? (4'b0001 << w_idx) : 4'b0000;
  assign w_cap = w_accept & w_one & w_legal;
  assign w_err = w_accept & ~w_blank & ~(w_one & w_legal);

  // Frame FSM: the seen mask is the state (COLLECT until all four bits).
  always_ff @(posedge clk) begin
    if (reset) r_seen <= '0;
    else       r_seen <= w_seen_nxt;
  end

  always_comb begin
    w_seen_nxt = r_seen;
    if (w_cap) begin
      if ((r_seen | w_sel) == 4'hF) w_seen_nxt = 4'h0;
      else                          w_seen_nxt = r_seen | w_sel;
    end
  end

  always_comb begin
    w_done = w_cap && ((r_seen | w_sel) == 4'hF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) r_num[k] <= '0;
      r_valid <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ec    <= '0;
    end else begin
      r_done <= w_done;
      r_err  <= w_err;
      if (w_cap) begin
        r_num[w_idx]   <= w_val;
        r_valid[w_idx] <= 1'b1;
      end
      if (w_err && r_ec != 8'hFF) r_ec <= r_ec + 8'd1;
    end
  end

  assign num0        = r_num[0];
  assign num1        = r_num[1];
  assign num2        = r_num[2];
  assign num3        = r_num[3];
  assign digit_valid = r_valid;
  assign frame_done  = r_done;
  assign pattern_err = r_err;
  assign err_count   = r_ec;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: two instances (STABLE_CNT 1 and 3) on shared
// inputs, checked every cycle against a run-length reference model.
module tb_seven_seg_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  logic [3:0] num_o [2][4];
  logic [3:0] dv_o [2];
  logic       fd_o [2];
  logic       pe_o [2];
  logic [7:0] ec_o [2];

  int n_cmp = 0;
  int n_bad = 0;

  localparam int NS [2] = '{1, 3};
  localparam logic [10:0] BLANK = 11'h7FF;

  logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                           7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                           7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seven_seg_capture #(.STABLE_CNT(1)) u_n1 (
    .clk(clk), .reset(reset), .seg(seg), .dp(dp), .an(an),
    .num0(num_o[0][0]), .num1(num_o[0][1]),
    .num2(num_o[0][2]), .num3(num_o[0][3]),
    .digit_valid(dv_o[0]), .frame_done(fd_o[0]),
    .pattern_err(pe_o[0]), .err_count(ec_o[0])
  );

  seven_seg_capture #(.STABLE_CNT(3)) u_n3 (
    .clk(clk), .reset(reset), .seg(seg), .dp(dp), .an(an),
    .num0(num_o[1][0]), .num1(num_o[1][1]),
    .num2(num_o[1][2]), .num3(num_o[1][3]),
    .digit_valid(dv_o[1]), .frame_done(fd_o[1]),
    .pattern_err(pe_o[1]), .err_count(ec_o[1])
  );

  // reference model state
  logic [3:0]  m_num [2][4];
  logic [3:0]  m_valid [2];
  logic [3:0]  m_seen [2];
  logic        m_fd [2];
  logic        m_pe [2];
  int          m_ec [2];
  bit          m_pend [2];
  logic [10:0] m_pval [2];
  logic [10:0] m_last;
  int          m_run;

  task automatic chk(input string tag, input int i,
                     input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[N=%0d] observed=%0h expected=%0h",
             tag, NS[i], obs, exp);
    end
  endtask

  function automatic int find_digit(input logic [6:0] p);
    for (int d = 0; d < 16; d++) if (PAT[d] == p) return d;
    return -1;
  endfunction

  task automatic apply(input int i, input logic [10:0] v);
    logic [3:0] a;
    logic [6:0] s;
    int d;
    int k;
    a = v[3:0];
    s = v[10:4];
    if (a == 4'hF) return;
    d = find_digit(~s);
    if ($countones(~a) != 1 || d < 0) begin
      m_pe[i] = 1'b1;
      if (m_ec[i] < 255) m_ec[i]++;
      return;
    end
    k = 0;
    for (int j = 0; j < 4; j++) if (!a[j]) k = j;
    m_num[i][k]   = 4'(d);
    m_valid[i][k] = 1'b1;
    m_seen[i][k]  = 1'b1;
    if (m_seen[i] == 4'hF) begin
      m_fd[i]   = 1'b1;
      m_seen[i] = 4'h0;
    end
  endtask

  task automatic model_step(input logic r);
    logic [10:0] x;
    x = {seg, an};
    for (int i = 0; i < 2; i++) begin
      m_fd[i] = 1'b0;
      m_pe[i] = 1'b0;
    end
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 4; k++) m_num[i][k] = 4'h0;
        m_valid[i] = 4'h0;
        m_seen[i]  = 4'h0;
        m_ec[i]    = 0;
        m_pend[i]  = 1'b0;
      end
      m_last = BLANK;
      m_run  = 1;
    end else begin
      for (int i = 0; i < 2; i++) if (m_pend[i]) apply(i, m_pval[i]);
      if (x == m_last) m_run++;
      else m_run = 1;
      m_last = x;
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = (m_run == NS[i]);
        m_pval[i] = x;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("num%0d", k), i, 8'(num_o[i][k]), 8'(m_num[i][k]));
      chk("digit_valid", i, 8'(dv_o[i]), 8'(m_valid[i]));
      chk("frame_done", i, 8'(fd_o[i]), 8'(m_fd[i]));
      chk("pattern_err", i, 8'(pe_o[i]), 8'(m_pe[i]));
      chk("err_count", i, ec_o[i], 8'(m_ec[i]));
    end
  endtask

  task automatic tick(input logic [6:0] s, input logic [3:0] a,
                      input logic r);
    seg   = s;
    an    = a;
    reset = r;
    dp    = 1'($urandom);
    @(posedge clk);
    model_step(r);
    #1;
    check_all();
  endtask

  initial begin
    int nfd;
    int hold;
    int kind;
    logic [6:0] s;
    logic [3:0] a;

    seg = 7'h7F; an = 4'hF; dp = 1'b0; reset = 1'b1;
    m_last = BLANK; m_run = 1;

    repeat (3) tick(7'h7F, 4'hF, 1'b1);
    for (int i = 0; i < 2; i++) chk("rst_valid", i, 8'(dv_o[i]), 8'h00);
    repeat (2) tick(7'h7F, 4'hF, 1'b0);

    // scanning driver loopback: 4,3,2,1 left to right, one cycle each
    nfd = 0;
    for (int c = 0; c < 16; c++) begin
      tick(~PAT[(c % 4) + 1], 4'(~(4'b0001 << (c % 4))), 1'b0);
      if (fd_o[0]) nfd++;
    end
    chk("loop_fd_cnt", 0, 8'(nfd), 8'd3);
    for (int k = 0; k < 4; k++)
      chk("loop_num", 0, 8'(num_o[0][k]), 8'(k + 1));
    chk("loop_valid", 0, 8'(dv_o[0]), 8'h0F);
    chk("loop_n3_valid", 1, 8'(dv_o[1]), 8'h00);

    // STABLE_CNT=3: short hold ignored, long hold captures at 4th edge
    repeat (2) tick(~7'h06, 4'b1110, 1'b0);
    tick(7'h7F, 4'hF, 1'b0);
    for (int j = 0; j < 5; j++) begin
      tick(~7'h06, 4'b1110, 1'b0);
      chk("n3_num0_t", 1, 8'(num_o[1][0]), (j >= 3) ? 8'd1 : 8'd0);
    end

    // blank segments with a strobe: illegal pattern
    repeat (4) tick(~7'h00, 4'b1110, 1'b0);
    chk("blank_ec", 0, ec_o[0], 8'd1);
    chk("blank_ec", 1, ec_o[1], 8'd1);
    chk("blank_num0", 1, 8'(num_o[1][0]), 8'd1);

    // two strobes low with a legal pattern
    repeat (4) tick(~PAT[5], 4'b1100, 1'b0);
    chk("multi_ec", 0, ec_o[0], 8'd2);

    // reset after two digits, then a fresh full scan
    repeat (4) tick(~PAT[7], 4'b1110, 1'b0);
    repeat (4) tick(~PAT[8], 4'b1101, 1'b0);
    repeat (2) tick(7'h7F, 4'hF, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_valid", i, 8'(dv_o[i]), 8'h00);
      chk("mid_rst_ec", i, ec_o[i], 8'h00);
    end
    nfd = 0;
    for (int k = 0; k < 4; k++)
      repeat (4) begin
        tick(~PAT[9 - k], 4'(~(4'b0001 << k)), 1'b0);
        if (fd_o[1]) nfd++;
      end
    tick(7'h7F, 4'hF, 1'b0);
    if (fd_o[1]) nfd++;
    chk("rescan_fd_cnt", 1, 8'(nfd), 8'd1);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 5);
      s = ~PAT[$urandom_range(0, 15)];
      a = 4'(~(4'b0001 << $urandom_range(0, 3)));
      if (kind == 0) begin
        s = 7'h7F;
        a = 4'hF;
      end else if (kind == 1) begin
        a = 4'($urandom_range(0, 15));
        if ($countones(~a) < 2) a = 4'b0101;
      end else if (kind == 2) begin
        s = 7'($urandom);
      end
      repeat (hold) tick(s, a, 1'b0);
    end

    // error counter saturation
    for (int j = 0; j < 300; j++)
      repeat (3) tick((j % 2) ? 7'h7F : 7'h7E, 4'b1110, 1'b0);
    chk("ec_sat", 0, ec_o[0], 8'd255);
    chk("ec_sat", 1, ec_o[1], 8'd255);
    for (int j = 0; j < 4; j++)
      repeat (3) tick((j % 2) ? 7'h7F : 7'h7E, 4'b1110, 1'b0);
    chk("ec_hold", 0, ec_o[0], 8'd255);
    chk("ec_hold", 1, ec_o[1], 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
